// File: rtl/read_cycle_if.sv
// read_cycle_if: request/response and LCD pin bundle for the LCD read sequencer.
// The master side drives requests and the LCD data bus; the slave side is read_cycle itself.
interface read_cycle_if;
  logic       rd_enable;
  logic       reg_sel;
  logic [7:0] lcd_d_in;
  logic [7:0] rd_data;
  logic       rd_finish;
  logic       rd_timeout;
  logic       bus_release;
  logic       E_out;
  logic       RW_out;
  logic       RS_out;

  modport master (
    output rd_enable, reg_sel, lcd_d_in,
    input  rd_data, rd_finish, rd_timeout, bus_release, E_out, RW_out, RS_out
  );

  modport slave (
    input  rd_enable, reg_sel, lcd_d_in,
    output rd_data, rd_finish, rd_timeout, bus_release, E_out, RW_out, RS_out
  );
endinterface

// File: rtl/read_cycle.sv
// read_cycle: HD44780 read sequencer (setup / E-high / hold) that samples the LCD data bus.
// Busy-flag re-polling of instruction reads is enabled by defining READ_CYCLE_BUSY_POLL_EN.
module read_cycle #(
  parameter int SETUP_TICKS  = 1,
  parameter int E_HIGH_TICKS = 1,
  parameter int MAX_POLLS    = 8
) (
  input  logic        clk_1ms,
  input  logic        reset,
  read_cycle_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] EHIGH = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_TICKS - 1);
  localparam logic [3:0] EHIGH_LAST = 4'(E_HIGH_TICKS - 1);

  if ((SETUP_TICKS < 1) || (SETUP_TICKS > 15) || (E_HIGH_TICKS < 1) || (E_HIGH_TICKS > 15) ||
      (MAX_POLLS < 1) || (MAX_POLLS > 255)) begin : g_param_check
    $error("read_cycle: timing/poll parameter out of range");
  end

  logic [2:0] state_r, state_s;
  logic [3:0] tick_r, tick_s;
  logic       rs_r, rs_s;
  logic [7:0] rd_data_r, rd_data_s;
  logic       e_r;
  logic       rw_r;
  logic       finish_r;

`ifdef READ_CYCLE_BUSY_POLL_EN
  localparam logic [7:0] POLL_LAST = 8'(MAX_POLLS - 1);

  logic [7:0] poll_r, poll_s;
  logic       timeout_r, timeout_s;
`endif

  // Next-state, tick counter, register-select latch and data capture.
  always_comb begin
    state_s   = state_r;
    tick_s    = tick_r;
    rs_s      = rs_r;
    rd_data_s = rd_data_r;
`ifdef READ_CYCLE_BUSY_POLL_EN
    poll_s    = poll_r;
    timeout_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (bus.rd_enable) begin
          rs_s    = bus.reg_sel;
          tick_s  = 4'd0;
          state_s = SETUP;
`ifdef READ_CYCLE_BUSY_POLL_EN
          poll_s  = 8'd0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (tick_r == SETUP_LAST) begin
          tick_s  = 4'd0;
          state_s = EHIGH;
        end else begin
          tick_s  = tick_r + 4'd1;
        end
      end
      EHIGH: begin
        if (tick_r == EHIGH_LAST) begin
          tick_s    = 4'd0;
          rd_data_s = bus.lcd_d_in;
          state_s   = HOLD;
        end else begin
          tick_s    = tick_r + 4'd1;
        end
      end
      HOLD: begin
`ifdef READ_CYCLE_BUSY_POLL_EN
        // Instruction reads with the busy flag set retry until the poll budget runs out.
        if (!rs_r && rd_data_r[7] && (poll_r < POLL_LAST)) begin
          poll_s  = poll_r + 8'd1;
          tick_s  = 4'd0;
          state_s = SETUP;
        end else begin
          timeout_s = !rs_r && rd_data_r[7];
          state_s   = DONE;
        end
`else
        state_s = DONE;
`endif
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, counters and outputs registered from the next state so pins never glitch.
  always_ff @(posedge clk_1ms or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      tick_r    <= 4'd0;
      rs_r      <= 1'b0;
      rd_data_r <= 8'h00;
      e_r       <= 1'b0;
      rw_r      <= 1'b0;
      finish_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      tick_r    <= tick_s;
      rs_r      <= rs_s;
      rd_data_r <= rd_data_s;
      e_r       <= (state_s == EHIGH);
      rw_r      <= (state_s == SETUP) || (state_s == EHIGH) || (state_s == HOLD);
      finish_r  <= (state_s == DONE);
    end
  end

`ifdef READ_CYCLE_BUSY_POLL_EN
  // Poll counter and timeout strobe (coincides with the DONE cycle).
  always_ff @(posedge clk_1ms or negedge reset) begin
    if (!reset) begin
      poll_r    <= 8'd0;
      timeout_r <= 1'b0;
    end else begin
      poll_r    <= poll_s;
      timeout_r <= timeout_s;
    end
  end

  assign bus.rd_timeout = timeout_r;
`else
  assign bus.rd_timeout = 1'b0;
`endif

  // The data bus is released for exactly the cycles the LCD is in read mode.
  assign bus.rd_data     = rd_data_r;
  assign bus.rd_finish   = finish_r;
  assign bus.bus_release = rw_r;
  assign bus.E_out       = e_r;
  assign bus.RW_out      = rw_r;
  assign bus.RS_out      = rs_r;

endmodule

// File: doc/read_cycle.md
Name: read_cycle

Overview:
- Reads one byte from the HD44780-style character LCD. This is the read-side counterpart of the LCD write cycle.
- Drives RS, RW and E through a setup / E-high / hold sequence.
- Samples the 8-bit LCD data bus while E is high and returns the byte with a one-cycle finish strobe.
- Sits beside the write cycle in the LCD controller and is clocked by the same 1 ms tick clock. The top level releases the shared data bus whenever bus_release=1.

Parameters:
- SETUP_TICKS, 1, clock cycles with RS/RW valid and E low before E rises; legal range 1..15.
- E_HIGH_TICKS, 1, clock cycles E is held high; legal range 1..15.
- MAX_POLLS, 8, busy-poll retry limit; used only with BUSY_POLL_EN; legal range 1..255.

Ports:
- clk_1ms  input  1  1 ms system tick clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- rd_enable  input  1  start request, sampled only in IDLE.
- reg_sel  input  1  0 = instruction register (busy flag/address), 1 = data register; latched at start.
- lcd_d_in  input  8  LCD data bus as seen by the FPGA.
- rd_data  output  8  last sampled byte.
- rd_finish  output  1  one-cycle strobe: rd_data valid.
- rd_timeout  output  1  one-cycle strobe alongside rd_finish when the busy poll expires; constant 0 without BUSY_POLL_EN.
- bus_release  output  1  1 = top level must tristate its data drivers.
- E_out  output  1  LCD enable.
- RW_out  output  1  LCD R/W (1 = read).
- RS_out  output  1  LCD register select.

Behaviour:
- Reset (reset=0, asynchronous), applies immediately including mid-cycle:
  - state=IDLE; E_out=0, RW_out=0, RS_out=0, bus_release=0.
  - rd_finish=0, rd_timeout=0, rd_data=8'h00.
  - tick counter and poll counter cleared.
- All outputs are registered or decoded from registered state; none depend combinationally on inputs.
- States IDLE, SETUP, EHIGH, HOLD, DONE; 4-bit tick counter; 8-bit poll counter.
- IDLE:
  - If rd_enable=1 at an edge: latch reg_sel into rs_q, clear the tick counter, go to SETUP.
  - Otherwise stay in IDLE.
- SETUP:
  - RW_out=1, RS_out=rs_q, bus_release=1, E_out=0.
  - Lasts SETUP_TICKS cycles, then go to EHIGH.
- EHIGH:
  - E_out=1; RW_out, RS_out and bus_release as in SETUP.
  - Lasts E_HIGH_TICKS cycles.
  - On the edge ending the last EHIGH cycle, capture lcd_d_in into rd_data, then go to HOLD.
- HOLD:
  - E_out=0; RW_out, RS_out and bus_release still held as in SETUP.
  - Lasts 1 cycle, then go to DONE.
- DONE:
  - rd_finish=1 for exactly one cycle; RW_out=0, bus_release=0.
  - Next state is IDLE.
- Latency with defaults:
  - rd_enable sampled at edge k.
  - SETUP during cycle k+1, E high during cycle k+2, HOLD during cycle k+3.
  - rd_finish=1 during cycle k+4.
- Back-to-back: rd_enable held at 1 starts a new read on the edge leaving IDLE, so the minimum period is 5 cycles with defaults.
- rd_enable and reg_sel changes outside IDLE are ignored.
- rd_data holds its value until the next capture, including across rd_enable=0.
- RS_out holds rs_q in IDLE. RW_out returns to 0 (write default) in IDLE and DONE, so the write cycle's bus assumptions stay valid.

Optional Feature:
- Macro: READ_CYCLE_BUSY_POLL_EN.
- Defined:
  - After HOLD, if rs_q=0 and rd_data[7]=1 (busy) and the poll count is below MAX_POLLS-1: increment the poll count and return to SETUP. No rd_finish is issued.
  - When the busy flag clears: go to DONE as normal.
  - When the limit is reached with busy still set: go to DONE with rd_timeout=1 in the same cycle as rd_finish.
  - The poll count clears on leaving IDLE.
  - Reads with rs_q=1 never repeat.
- Undefined: single read per request; rd_timeout tied to 0; poll counter absent.

Test Plan:
- Reset: reset=0 mid-EHIGH with E_out=1 -> E_out, RW_out, bus_release and rd_finish go to 0 asynchronously; state=IDLE after release.
- Single data read (defaults): reg_sel=1, lcd_d_in=8'hA5, rd_enable pulse at edge k -> RW_out=1 and RS_out=1 during cycles k+1..k+3; E_out=1 only in cycle k+2; rd_finish=1 only in cycle k+4; rd_data=8'hA5.
- Sampling point: lcd_d_in=8'h3C during E high, changed to 8'hFF in HOLD -> rd_data=8'h3C.
- Timing parameters: SETUP_TICKS=3, E_HIGH_TICKS=2 -> E_out high for exactly 2 cycles starting 4 cycles after the start edge; rd_finish 7 cycles after the start edge.
- Ignored inputs: rd_enable held at 1 and reg_sel toggled mid-cycle -> RS_out stable for the whole read; next read starts on the edge after DONE.
- BUSY_POLL_EN: reg_sel=0, lcd_d_in=8'h80 for 2 reads then 8'h05 -> 3 E pulses, one rd_finish, rd_data=8'h05, rd_timeout=0. With lcd_d_in stuck at 8'h80 and MAX_POLLS=4 -> 4 E pulses, then rd_finish=1 and rd_timeout=1 in the same cycle.
